rob: RTL and testbench

Reorder buffer for the out-of-order core: circular queue of in-flight instructions that sits between the ID stage and the register file. It responds to ID's tag-allocation requests, captures results broadcast by the execution units, and retires entries strictly in program order, driving the register-file write-back port. It is the responder for the ROB-position interface that ID uses to obtain `target` tags.

---
 rtl/rob.sv | 123 ++++++++++++
 tb/tb_rob.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions, allocated in order and retired in order.
// Latency: tag usable on CDB one edge after allocation; commit appears one cycle after the result is captured.
// Backpressure: allocation refused while full (ID retries); at most one retire per cycle.
module rob #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_req,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic              alloc_rd_en,
  input  logic [OP_W-1:0]   alloc_op,
  output logic [TAG_W-1:0]  avail_tag,
  output logic              full,
  output logic [TAG_W:0]    count,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              commit_valid,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_rd,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_val
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-1:0] TAG_INVALID = '1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  // Per-entry status bits (reset) and payload (no reset needed, always written before use)
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  rd_en_q;
  logic [REG_W-1:0]  rd_q  [DEPTH];
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [DATA_W-1:0] val_q [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [TAG_W:0]    count_q;

  logic              alloc_ok;
  logic              retire;
  logic              cap_ok;
  logic [PTR_W-1:0]  cap_idx;
  logic              clear;

  // Opcode of the oldest entry, kept visible for debug probing only.
  logic [OP_W-1:0]   head_op_unused;

  assign clear     = rst || flush;
  assign full      = (count_q == (TAG_W+1)'(DEPTH));
  assign count     = count_q;
  assign avail_tag = full ? TAG_INVALID : TAG_W'(tail);

  // Full is judged on registered state, so a retire at the same edge does not admit an alloc.
  assign alloc_ok  = alloc_req && !full;
  // Retire only looks at the registered ready bit: one-cycle capture-to-commit.
  assign retire    = busy[head] && ready[head];
  assign cap_idx   = cdb_tag[PTR_W-1:0];
  // Out-of-range tags (including the invalid tag) and stale tags of freed entries are ignored.
  assign cap_ok    = cdb_valid && (cdb_tag < TAG_W'(DEPTH)) && busy[cap_idx];

  assign head_op_unused = op_q[head];

  // Status bits, pointers, occupancy and registered retire port; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      busy         <= '0;
      ready        <= '0;
      head         <= '0;
      tail         <= '0;
      count_q      <= '0;
      commit_valid <= 1'b0;
      wb_en        <= 1'b0;
      wb_rd        <= '0;
      wb_tag       <= TAG_INVALID;
      wb_val       <= '0;
    end else begin
      if (cap_ok) begin
        ready[cap_idx] <= 1'b1;
      end
      if (retire) begin
        busy[head]   <= 1'b0;
        ready[head]  <= 1'b0;
        head         <= head + PTR_ONE;
        commit_valid <= 1'b1;
        wb_en        <= rd_en_q[head] && (rd_q[head] != '0);
        wb_rd        <= rd_q[head];
        wb_tag       <= TAG_W'(head);
        wb_val       <= val_q[head];
      end else begin
        commit_valid <= 1'b0;
        wb_en        <= 1'b0;
      end
      // Tail entry is never busy when not full, so this cannot collide with capture or retire.
      if (alloc_ok) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + PTR_ONE;
      end
      count_q <= count_q + (TAG_W+1)'(alloc_ok) - (TAG_W+1)'(retire);
    end
  end

  // Entry payload: destination/opcode on allocation, result value on capture.
  always_ff @(posedge clk) begin
    if (!clear && alloc_ok) begin
      rd_q[tail]    <= alloc_rd;
      rd_en_q[tail] <= alloc_rd_en;
      op_q[tail]    <= alloc_op;
    end
    if (!clear && cap_ok) begin
      val_q[cap_idx] <= cdb_val;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Bench for the reorder buffer: directed stimulus with a scoreboard of expected commits.
// Expected commits are queued by the stimulus; a negedge monitor pops and compares them.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_req = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        alloc_rd_en = 1'b0;
  logic [5:0]  alloc_op = '0;
  logic [3:0]  avail_tag;
  logic        full;
  logic [4:0]  count;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_val = '0;
  logic        commit_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [3:0]  wb_tag;
  logic [31:0] wb_val;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic        en;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  rob dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req(alloc_req), .alloc_rd(alloc_rd), .alloc_rd_en(alloc_rd_en), .alloc_op(alloc_op),
    .avail_tag(avail_tag), .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .commit_valid(commit_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_tag(wb_tag), .wb_val(wb_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_commit(input logic [3:0] t, input logic [4:0] r, input logic en,
                               input logic [31:0] v);
    exp_t e;
    e.tag = t; e.rd = r; e.en = en; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_alloc(input logic [4:0] r, input logic en, input logic [3:0] exp_tag);
    chk("alloc_avail_tag", 64'(avail_tag), 64'(exp_tag));
    alloc_req = 1'b1; alloc_rd = r; alloc_rd_en = en; alloc_op = 6'h2A;
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic do_cdb(input logic [3:0] t, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_val = v;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_all_committed", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every retire must match the oldest expected commit.
  always @(negedge clk) begin
    if (commit_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_commit: got tag %0d expected no commit at %0t", wb_tag, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_tag", 64'(wb_tag), 64'(e.tag));
        chk("wb_rd",  64'(wb_rd),  64'(e.rd));
        chk("wb_en",  64'(wb_en),  64'(e.en));
        chk("wb_val", 64'(wb_val), 64'(e.val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_avail_tag", 64'(avail_tag), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_wb_tag", 64'(wb_tag), 64'hF);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_val", 64'(wb_val), 64'd0);

    // In-order completion of three entries
    do_alloc(5'd1, 1'b1, 4'd0);
    do_alloc(5'd2, 1'b1, 4'd1);
    do_alloc(5'd3, 1'b1, 4'd2);
    chk("t1_count", 64'(count), 64'd3);
    expect_commit(4'd0, 5'd1, 1'b1, 32'h11);
    expect_commit(4'd1, 5'd2, 1'b1, 32'h22);
    expect_commit(4'd2, 5'd3, 1'b1, 32'h33);
    do_cdb(4'd0, 32'h11);
    do_cdb(4'd1, 32'h22);
    do_cdb(4'd2, 32'h33);
    drain();
    chk("t1_count_end", 64'(count), 64'd0);

    // Out-of-order completion
    do_reset();
    do_alloc(5'd4, 1'b1, 4'd0);
    do_alloc(5'd5, 1'b1, 4'd1);
    expect_commit(4'd0, 5'd4, 1'b1, 32'hA);
    expect_commit(4'd1, 5'd5, 1'b1, 32'hB);
    do_cdb(4'd1, 32'hB);
    tick();
    chk("t2_no_commit_a", 64'(commit_valid), 64'd0);
    tick();
    chk("t2_no_commit_b", 64'(commit_valid), 64'd0);
    do_cdb(4'd0, 32'hA);
    chk("t2_capture_cycle", 64'(commit_valid), 64'd0);
    tick();
    chk("t2_commit_tag0_valid", 64'(commit_valid), 64'd1);
    chk("t2_commit_tag0_tag", 64'(wb_tag), 64'd0);
    tick();
    chk("t2_commit_tag1_valid", 64'(commit_valid), 64'd1);
    chk("t2_commit_tag1_tag", 64'(wb_tag), 64'd1);
    tick();
    chk("t2_commit_done", 64'(commit_valid), 64'd0);
    drain();

    // Full boundary
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(5'(i + 1), 1'b1, 4'(i));
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_avail_invalid", 64'(avail_tag), 64'hF);
    chk("t3_count8", 64'(count), 64'd8);
    expect_commit(4'd0, 5'd1, 1'b1, 32'h100);
    do_cdb(4'd0, 32'h100);
    alloc_req = 1'b1; alloc_rd = 5'd9; alloc_rd_en = 1'b1; alloc_op = 6'h01;
    chk("t3_full_before_retire", 64'(full), 64'd1);
    tick();
    chk("t3_refused_count", 64'(count), 64'd7);
    chk("t3_refused_full", 64'(full), 64'd0);
    chk("t3_freed_avail", 64'(avail_tag), 64'd0);
    tick();
    alloc_req = 1'b0;
    chk("t3_accepted_count", 64'(count), 64'd8);
    chk("t3_accepted_full", 64'(full), 64'd1);
    for (int t = 1; t < 8; t++) expect_commit(4'(t), 5'(t + 1), 1'b1, 32'h200 + 32'(t));
    expect_commit(4'd0, 5'd9, 1'b1, 32'h999);
    for (int t = 1; t < 8; t++) do_cdb(4'(t), 32'h200 + 32'(t));
    do_cdb(4'd0, 32'h999);
    drain();
    chk("t3_count_end", 64'(count), 64'd0);

    // Wrap-around over many sequences
    do_reset();
    for (int i = 0; i < 20; i++) begin
      expect_commit(4'(i % 8), 5'((i % 31) + 1), 1'b1, 32'h1000 + 32'(i));
      do_alloc(5'((i % 31) + 1), 1'b1, 4'(i % 8));
      do_cdb(4'(i % 8), 32'h1000 + 32'(i));
    end
    drain();
    chk("t4_count_end", 64'(count), 64'd0);
    chk("t4_avail_end", 64'(avail_tag), 64'd4);

    // No register write for rd_en=0 or rd=0
    expect_commit(4'd4, 5'd5, 1'b0, 32'h55);
    expect_commit(4'd5, 5'd0, 1'b0, 32'h66);
    do_alloc(5'd5, 1'b0, 4'd4);
    do_alloc(5'd0, 1'b1, 4'd5);
    do_cdb(4'd4, 32'h55);
    do_cdb(4'd5, 32'h66);
    drain();
    chk("t5_count_end", 64'(count), 64'd0);
    chk("t5_avail_end", 64'(avail_tag), 64'd6);

    // Flush with entries in flight plus simultaneous alloc and CDB
    do_reset();
    for (int i = 0; i < 5; i++) do_alloc(5'(i + 10), 1'b1, 4'(i));
    do_cdb(4'd0, 32'hAA);
    flush = 1'b1;
    alloc_req = 1'b1; alloc_rd = 5'd20; alloc_rd_en = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_val = 32'hBB;
    tick();
    flush = 1'b0; alloc_req = 1'b0; cdb_valid = 1'b0;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_avail", 64'(avail_tag), 64'd0);
    chk("t6_full", 64'(full), 64'd0);
    chk("t6_commit_valid", 64'(commit_valid), 64'd0);
    chk("t6_wb_en", 64'(wb_en), 64'd0);
    chk("t6_wb_tag", 64'(wb_tag), 64'hF);
    do_cdb(4'd2, 32'hCC);
    do_cdb(4'hF, 32'hDD);
    tick();
    chk("t6_stale_cdb_no_commit", 64'(commit_valid), 64'd0);
    chk("t6_stale_count", 64'(count), 64'd0);
    expect_commit(4'd0, 5'd7, 1'b1, 32'h77);
    do_alloc(5'd7, 1'b1, 4'd0);
    do_cdb(4'd0, 32'h77);
    drain();
    chk("t6_count_end", 64'(count), 64'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
